// File: rtl/xtea_pkg.sv
// Shared XTEA constants and FSM state encoding.
// Imported by both the encryptor and the decryptor.
package xtea_pkg;

  localparam int unsigned XTEA_ROUNDS       = 32;
  localparam logic [31:0] XTEA_DELTA        = 32'h9E3779B9;
  localparam logic [31:0] XTEA_DEC_INIT_SUM = 32'hC6EF3720;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOP     = 3'd1,
    ST_UPDATE_Y = 3'd2,
    ST_UPDATE_Z = 3'd3,
    ST_DONE     = 3'd4
  } xtea_state_e;

  // Picks K[sel] out of the 128-bit key, where K[n] = key[32n+31:32n].
  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] sel);
    return k[32*sel +: 32];
  endfunction

endpackage

// File: rtl/xtea_enc_if.sv
// Request/response bundle for the XTEA encryptor.
interface xtea_enc_if;
  logic         en;
  logic         start;
  logic [127:0] data_i;
  logic [127:0] key;
  logic         ready;
  logic         busy;
  logic [127:0] data_o;

  modport master (output en, start, data_i, key, input ready, busy, data_o);
  modport slave  (input en, start, data_i, key, output ready, busy, data_o);
endinterface

// File: rtl/xtea_mix.sv
// XTEA mixing function: (((v<<4)^(v>>5))+v) ^ (s+k), all mod 2^32.
module xtea_mix (
  input  logic [31:0] v,
  input  logic [31:0] s,
  input  logic [31:0] k,
  output logic [31:0] f
);

  assign f = (((v << 4) ^ (v >> 5)) + v) ^ (s + k);

endmodule

// File: rtl/xtea_enc.sv
// Two-lane iterative XTEA encryptor; one half-round per cycle, both lanes
// sharing the sum and key.
module xtea_enc
  import xtea_pkg::*;
#(
  parameter int unsigned ROUNDS = XTEA_ROUNDS,
  parameter logic [31:0] DELTA  = XTEA_DELTA
) (
  input  logic       clock,
  input  logic       reset,
  xtea_enc_if.slave  bus
);

  localparam int unsigned IW = $clog2(ROUNDS + 1);

  xtea_state_e        state_reg, state_next;
  logic [31:0]        sum_reg;
  logic [IW-1:0]      i_reg;
  logic [127:0]       key_reg;
  logic [1:0][31:0]   y_reg, z_reg;
  logic [127:0]       result_reg;

  logic               in_update_z;
  logic [1:0]         key_sel;
  logic [31:0]        key_mux;
  logic [1:0][31:0]   mix_v, mix_out;
  logic               rounds_left;

  assign rounds_left = (i_reg < IW'(ROUNDS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    bus.ready  = 1'b0;
    bus.busy   = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start && bus.en) state_next = ST_LOOP;
      end
      ST_LOOP:     state_next = rounds_left ? ST_UPDATE_Y : ST_DONE;
      ST_UPDATE_Y: state_next = ST_UPDATE_Z;
      ST_UPDATE_Z: state_next = ST_LOOP;
      ST_DONE: begin
        bus.ready  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        bus.busy   = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // The z half-round sees the already-advanced sum and the fresh y, so a
  // single mixer per lane serves both half-rounds by swapping its operand.
  assign in_update_z = (state_reg == ST_UPDATE_Z);
  assign key_sel     = in_update_z ? sum_reg[12:11] : sum_reg[1:0];
  assign key_mux     = key_word(key_reg, key_sel);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign mix_v[gi] = in_update_z ? y_reg[gi] : z_reg[gi];
      xtea_mix u_mix (
        .v (mix_v[gi]),
        .s (sum_reg),
        .k (key_mux),
        .f (mix_out[gi])
      );
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_reg    <= '0;
      i_reg      <= '0;
      key_reg    <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          key_reg <= bus.key;
          sum_reg <= '0;
          i_reg   <= '0;
          for (int l = 0; l < 2; l++) begin
            y_reg[l] <= bus.data_i[64*l +: 32];
            z_reg[l] <= bus.data_i[64*l+32 +: 32];
          end
        end
        ST_LOOP: begin
          if (!rounds_left) result_reg <= {z_reg[1], y_reg[1], z_reg[0], y_reg[0]};
        end
        ST_UPDATE_Y: begin
          for (int l = 0; l < 2; l++) y_reg[l] <= y_reg[l] + mix_out[l];
          sum_reg <= sum_reg + DELTA;
        end
        ST_UPDATE_Z: begin
          for (int l = 0; l < 2; l++) z_reg[l] <= z_reg[l] + mix_out[l];
          i_reg <= i_reg + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.data_o = result_reg;

endmodule
